multi_servo_pwm: RTL and testbench

- Parametrised multi-channel RC servo pulse generator; the successor to the single-channel servo driver in chipDispenser.
- One shared tick prescaler and one frame counter drive NUM_CH independent pulse outputs.
- Pulse width per frame is MIN_TICKS + position, in ticks.
- Positions are written per channel through a simple write port, shadowed, and applied only at frame boundaries, so no runt or stretched pulses occur.

---
 rtl/multi_servo_pwm.sv | 124 ++++++++++++
 tb/tb_multi_servo_pwm.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_servo_pwm.sv
// multi_servo_pwm: NUM_CH-channel RC servo pulse generator.
// One tick prescaler and one frame counter are shared by all channels. Each
// channel shadows its written position in `target` and promotes it to
// `active` only at frame start, so a pulse is never cut short or stretched.
// Optional feature macro: SERVO_SLEW_EN limits the per-frame change of
// `active` to SLEW_STEP positions.
module multi_servo_pwm #(
    parameter int NUM_CH      = 4,
    parameter int POS_W       = 8,
    parameter int CLK_DIV     = 195,
    parameter int MIN_TICKS   = 256,
    parameter int FRAME_TICKS = 4096,
    parameter int RESET_POS   = 128,
    parameter int SLEW_STEP   = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        wr_en,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
    input  logic [POS_W-1:0]                            wr_pos,
    input  logic [NUM_CH-1:0]                           ch_en,
    output logic [NUM_CH-1:0]                           servo_pulse,
    output logic                                        frame_strobe
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DW   = $clog2(CLK_DIV);
    localparam int FW   = $clog2(FRAME_TICKS);
    localparam int CW   = FW + 1;   // one spare bit so MIN_TICKS + position cannot overflow

    localparam logic [DW-1:0]    DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [FW-1:0]    FRAME_LAST = FW'(FRAME_TICKS - 1);
    localparam logic [CW-1:0]    MIN_W      = CW'(MIN_TICKS);
    localparam logic [POS_W-1:0] RST_POS    = POS_W'(RESET_POS);

    // Reject parameter sets that would break the width/overflow reasoning below
    if (NUM_CH < 1 || NUM_CH > 16 || CLK_DIV < 2 || SLEW_STEP < 1 ||
        FRAME_TICKS < MIN_TICKS + (1 << POS_W)) begin : g_param_check
        $error("multi_servo_pwm: illegal parameter combination");
    end

    logic [DW-1:0]     div_cnt;
    logic [FW-1:0]     frame_cnt;
    logic              tick;
    logic              frame_load;
    logic              wr_ok;
    logic [NUM_CH-1:0] en_lat;
    logic [NUM_CH-1:0] pulse_next;

    assign tick       = (div_cnt == DIV_LAST);
    assign frame_load = tick && (frame_cnt == FRAME_LAST);
    assign wr_ok      = wr_en && (32'(wr_ch) < 32'(NUM_CH));

    // Tick prescaler: free-running 0..CLK_DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    // Frame counter: advances once per tick, wraps only at FRAME_TICKS-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          frame_cnt <= '0;
        else if (frame_load) frame_cnt <= '0;
        else if (tick)       frame_cnt <= frame_cnt + 1'b1;
    end

    // Frame-start bookkeeping: latch channel enables and flag the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_lat       <= '0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= frame_load;
            if (frame_load) en_lat <= ch_en;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [POS_W-1:0] target;
        logic [POS_W-1:0] active;
        logic [POS_W-1:0] next_active;

        // Shadow writes into target; active changes only at frame start
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                target <= RST_POS;
                active <= RST_POS;
            end else begin
                if (wr_ok && wr_ch == CH_W'(i)) target <= wr_pos;
                if (frame_load)                 active <= next_active;
            end
        end

`ifdef SERVO_SLEW_EN
        localparam int               STEP_C = (SLEW_STEP > (1 << POS_W)) ? (1 << POS_W) : SLEW_STEP;
        localparam logic [POS_W:0]   STEP   = (POS_W + 1)'(STEP_C);
        logic [POS_W:0] diff;

        // Move toward target by at most STEP; never passes target, so no wrap
        always_comb begin
            diff        = '0;
            next_active = target;
            if (target > active) begin
                diff = {1'b0, target} - {1'b0, active};
                if (diff > STEP) next_active = active + STEP[POS_W-1:0];
            end else if (active > target) begin
                diff = {1'b0, active} - {1'b0, target};
                if (diff > STEP) next_active = active - STEP[POS_W-1:0];
            end
        end
`else
        assign next_active = target;
`endif

        assign pulse_next[i] = en_lat[i] && ({1'b0, frame_cnt} < MIN_W + CW'(active));
    end

    // Registered pulse outputs: high while the frame position is inside the width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) servo_pulse <= '0;
        else        servo_pulse <= pulse_next;
    end

endmodule

// File: tb/tb_multi_servo_pwm.sv
// tb_multi_servo_pwm: self-checking bench for multi_servo_pwm.
// A frame-level reference model (positions, enables, frame arithmetic on the
// bench's own edge count) predicts every output each cycle; table-driven and
// hand-written sequences additionally compare measured pulse widths against
// hand-computed constants. NUM_CH=3 so that wr_ch=3 is a legal out-of-range index.
module tb_multi_servo_pwm;
    localparam int NCH  = 3;
    localparam int PW   = 4;
    localparam int DIV  = 4;
    localparam int MINT = 8;
    localparam int FT   = 64;
    localparam int RP   = 8;
    localparam int SS   = 4;
    localparam int PER  = FT * DIV;   // clk cycles per frame

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           wr_en = 1'b0;
    logic [1:0]     wr_ch = '0;
    logic [PW-1:0]  wr_pos = '0;
    logic [NCH-1:0] ch_en = '1;
    logic [NCH-1:0] servo_pulse;
    logic           frame_strobe;

    multi_servo_pwm #(
        .NUM_CH(NCH), .POS_W(PW), .CLK_DIV(DIV), .MIN_TICKS(MINT),
        .FRAME_TICKS(FT), .RESET_POS(RP), .SLEW_STEP(SS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos),
        .ch_en(ch_en), .servo_pulse(servo_pulse), .frame_strobe(frame_strobe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int n;              // rising edges since reset release
    int tgt [NCH];
    int act [NCH];
    bit en_m[NCH];
    int meas[NCH];

    typedef struct {
        int ch;
        int pos;
        int w[NCH];     // expected high clk count per channel in the next frame
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, n);
        end
    endtask

    function automatic int slew(input int a, input int t);
`ifdef SERVO_SLEW_EN
        if (t > a) return (t - a > SS) ? a + SS : t;
        if (a > t) return (a - t > SS) ? a - SS : t;
        return t;
`else
        return t + 0 * a;
`endif
    endfunction

    // One clock: update the model with the inputs in force at this edge, then compare
    task automatic cycle();
        logic [NCH-1:0] exp_p;
        n++;
        if (n % PER == 0) begin
            for (int i = 0; i < NCH; i++) begin
                act[i]  = slew(act[i], tgt[i]);
                en_m[i] = ch_en[i];
            end
        end
        if (wr_en && int'(wr_ch) < NCH) tgt[wr_ch] = int'(wr_pos);
        @(posedge clk);
        #1;
        exp_p = '0;
        for (int i = 0; i < NCH; i++)
            if (en_m[i] && ((n - 1) % PER) < (MINT + act[i]) * DIV) exp_p[i] = 1'b1;
        chk("pulse_vec", int'(servo_pulse), int'(exp_p));
        chk("strobe", int'(frame_strobe), (n % PER == 0) ? 1 : 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_pulse", int'(servo_pulse), 0);
        chk("reset_strobe", int'(frame_strobe), 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < NCH; i++) begin
            tgt[i] = RP; act[i] = RP; en_m[i] = 1'b0;
        end
    endtask

    task automatic goto_offset(input int o);
        while (n % PER != o) cycle();
    endtask

    // Run one frame from a frame boundary, counting high cycles; optionally drop ch_en[1]
    task automatic measure(input int drop_at);
        for (int i = 0; i < NCH; i++) meas[i] = 0;
        for (int c = 0; c < PER; c++) begin
            if (c == drop_at) ch_en = 3'b101;
            cycle();
            for (int i = 0; i < NCH; i++) if (servo_pulse[i]) meas[i]++;
        end
    endtask

    task automatic write_pos(input int ch, input int pos);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_pos = PW'(pos);
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic wait_strobe();
        int k = 0;
        while (!frame_strobe && k < PER + 50) begin
            cycle();
            k++;
        end
        chk("strobe_after_release", k, PER);
    endtask

    initial begin
        int sl[3];
        tbl[0] = '{ch: 0, pos: 5,  w: '{52, 64, 64}};
        tbl[1] = '{ch: 1, pos: 12, w: '{52, 80, 64}};
        tbl[2] = '{ch: 3, pos: 0,  w: '{52, 80, 64}};   // out of range: ignored
        tbl[3] = '{ch: 2, pos: 4,  w: '{52, 80, 48}};
        tbl[4] = '{ch: 0, pos: 1,  w: '{36, 80, 48}};
        tbl[5] = '{ch: 1, pos: 15, w: '{36, 92, 48}};
        tbl[6] = '{ch: 2, pos: 0,  w: '{36, 92, 32}};
        tbl[7] = '{ch: 0, pos: 0,  w: '{32, 92, 32}};
`ifdef SERVO_SLEW_EN
        sl = '{80, 92, 92};
`else
        sl = '{92, 92, 92};
`endif

        #2;
        do_reset();
        // Frame 0 silent, first strobe at 256 clk, then 16-tick pulses
        wait_strobe();
        measure(-1);
        for (int i = 0; i < NCH; i++) chk("first_frame_width", meas[i], 64);

        // Mid-frame writes take effect from the next frame
        for (int t = 0; t < 8; t++) begin
            goto_offset(120);
            write_pos(tbl[t].ch, tbl[t].pos);
            goto_offset(0);
            measure(-1);
            for (int i = 0; i < NCH; i++) chk($sformatf("tbl%0d_ch%0d", t, i), meas[i], tbl[t].w[i]);
        end

        // Write on the frame-load edge: old width one more frame
        goto_offset(PER - 1);
        write_pos(1, 11);
        measure(-1);
        chk("wrload_old", meas[1], 92);
        measure(-1);
        chk("wrload_new", meas[1], 76);

        // Drop ch_en[1] mid-pulse: pulse completes, then channel stays low
        measure(20);
        chk("drop_ch1_completes", meas[1], 76);
        chk("drop_ch0_same", meas[0], 32);
        measure(-1);
        chk("drop_ch1_low", meas[1], 0);
        chk("drop_ch0_next", meas[0], 32);
        ch_en = 3'b111;

        // Reset while ch0 is mid-pulse
        repeat (20) cycle();
        chk("pre_reset_ch0_high", int'(servo_pulse[0]), 1);
        do_reset();
        wait_strobe();

        // Large position jump (slewed when enabled)
        goto_offset(120);
        write_pos(0, 15);
        goto_offset(0);
        for (int f = 0; f < 3; f++) begin
            measure(-1);
            chk($sformatf("jump_frame%0d", f), meas[0], sl[f]);
        end

        // Random writes and enable changes against the model
        for (int c = 0; c < 6 * PER; c++) begin
            wr_en  = ($urandom_range(7) == 0);
            wr_ch  = 2'($urandom_range(3));
            wr_pos = PW'($urandom_range(15));
            if ($urandom_range(63) == 0) ch_en = NCH'($urandom);
            cycle();
        end
        wr_en = 1'b0;
        repeat (PER) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
